// File: rtl/slt_serial_if.sv
// Operand/result bundle for slt_serial; master drives start and operands, slave returns busy/done/r1/eq.
// The uns select exists only when SLT_SERIAL_UNSIGNED_EN is defined.
interface slt_serial_if #(parameter int n = 32);
  logic         start;
  logic [n-1:0] r2;
  logic [n-1:0] r3;
  logic         busy;
  logic         done;
  logic [n-1:0] r1;
  logic         eq;
`ifdef SLT_SERIAL_UNSIGNED_EN
  logic         uns;

  modport master (output start, r2, r3, uns, input busy, done, r1, eq);
  modport slave  (input start, r2, r3, uns, output busy, done, r1, eq);
`else
  modport master (output start, r2, r3, input busy, done, r1, eq);
  modport slave  (input start, r2, r3, output busy, done, r1, eq);
`endif
endinterface

// File: rtl/slt_serial.sv
// Bit-serial set-less-than (r2 < r3), n+2 cycles start-to-done, start ignored while busy (no queuing).
// SLT_SERIAL_UNSIGNED_EN adds a per-operation uns select for unsigned compare.
module slt_serial #(
  parameter int n = 32
) (
  input  logic        clk,
  input  logic        rst,
  slt_serial_if.slave bus
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [n-1:0]  a;
  logic [n-1:0]  b;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          zf;
  logic          s_msb;
  logic          ci_msb;
  logic          co_msb;
  logic          sum_bit;
  logic          carry_out;
  logic          lt;
  logic          done_q;
  logic [n-1:0]  r1_q;
  logic          eq_q;
`ifdef SLT_SERIAL_UNSIGNED_EN
  logic          uns_q;
`endif

  // One full-adder slice of a + ~b + 1, i.e. a - b.
  always_comb begin
    sum_bit   = a[0] ^ ~b[0] ^ carry;
    carry_out = (a[0] & ~b[0]) | (carry & (a[0] ^ ~b[0]));
  end

`ifdef SLT_SERIAL_UNSIGNED_EN
  always_comb lt = uns_q ? ~co_msb : (s_msb ^ (ci_msb ^ co_msb));
`else
  always_comb lt = s_msb ^ (ci_msb ^ co_msb);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a      <= '0;
      b      <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      zf     <= 1'b0;
      s_msb  <= 1'b0;
      ci_msb <= 1'b0;
      co_msb <= 1'b0;
      done_q <= 1'b0;
      r1_q   <= '0;
      eq_q   <= 1'b0;
`ifdef SLT_SERIAL_UNSIGNED_EN
      uns_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a     <= bus.r2;
            b     <= bus.r3;
            cnt   <= '0;
            carry <= 1'b1;
            zf    <= 1'b1;
`ifdef SLT_SERIAL_UNSIGNED_EN
            uns_q <= bus.uns;
`endif
          end
        end
        RUN: begin
          a     <= a >> 1;
          b     <= b >> 1;
          carry <= carry_out;
          cnt   <= cnt + 1'b1;
          if (sum_bit) zf <= 1'b0;
          // MSB slice: keep what is needed for overflow-corrected sign.
          if (cnt == LAST) begin
            s_msb  <= sum_bit;
            ci_msb <= carry;
            co_msb <= carry_out;
          end
        end
        DONE: begin
          r1_q   <= {{(n-1){1'b0}}, lt};
          eq_q   <= zf;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.r1   = r1_q;
  assign bus.eq   = eq_q;

endmodule

// File: tb/tb_slt_serial.sv
// Directed and randomized checks of slt_serial at n=32: latency, overflow cases, equality, start masking, reset abort.
module tb_slt_serial;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  slt_serial_if #(.n(N)) bus();
  slt_serial #(.n(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Issues one start pulse from IDLE and watches 40 cycles; cycle 1 is the one after the start edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] r, output logic e, output int lat, output int pulses);
    lat = 0; pulses = 0; r = '0; e = 1'b0;
    @(negedge clk);
    bus.r2 = a; bus.r3 = b; bus.start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        pulses++;
        if (lat == 0) begin lat = i; r = bus.r1; e = bus.eq; end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.r2 = 32'd5; bus.r3 = 32'd7;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.r1 !== 32'd0) begin bad++; $display("FAIL reset_r1 got=%h want=0", bus.r1); end
    total++; if (bus.eq !== 1'b0) begin bad++; $display("FAIL reset_eq got=%b want=0", bus.eq); end
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] r; logic e; int lat, p;
    run_op(32'd5, 32'd7, r, e, lat, p);
    total++; if (lat != 34) begin bad++; $display("FAIL basic_latency got=%0d want=34", lat); end
    total++; if (p != 1) begin bad++; $display("FAIL basic_pulses got=%0d want=1", p); end
    total++; if (r !== 32'd1) begin bad++; $display("FAIL basic_r1 got=%h want=1", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_eq got=%b want=0", e); end
  endtask

  task automatic test_overflow();
    logic [N-1:0] r; logic e; int lat, p;
    run_op(32'h8000_0000, 32'h7FFF_FFFF, r, e, lat, p);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL ovf_signed got=%h want=1", r); end
    run_op(32'h7FFF_FFFF, 32'h8000_0000, r, e, lat, p);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL ovf_swapped got=%h want=0", r); end
`ifdef SLT_SERIAL_UNSIGNED_EN
    bus.uns = 1'b1;
    run_op(32'h8000_0000, 32'h7FFF_FFFF, r, e, lat, p);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL ovf_unsigned got=%h want=0", r); end
    run_op(32'h7FFF_FFFF, 32'h8000_0000, r, e, lat, p);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL ovf_unsigned_swapped got=%h want=1", r); end
    bus.uns = 1'b0;
`endif
  endtask

  task automatic test_equal();
    logic [N-1:0] r; logic e; int lat, p;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e, lat, p);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL eq_r1 got=%h want=0", r); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL eq_eq got=%b want=1", e); end
    run_op(32'hFFFF_FFFF, 32'h0, r, e, lat, p);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL neg1_r1 got=%h want=1", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL neg1_eq got=%b want=0", e); end
  endtask

  // Previous op left r1=1, eq=0; those must persist in IDLE.
  task automatic test_hold();
    repeat (5) @(negedge clk);
    total++; if (bus.r1 !== 32'd1) begin bad++; $display("FAIL hold_r1 got=%h want=1", bus.r1); end
    total++; if (bus.eq !== 1'b0) begin bad++; $display("FAIL hold_eq got=%b want=0", bus.eq); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL hold_done got=%b want=0", bus.done); end
  endtask

  task automatic test_ignore_start();
    int lat = 0, p = 0; logic [N-1:0] r = '0;
    @(negedge clk);
    bus.r2 = 32'hFFFF_FFFF; bus.r3 = 32'd3; bus.start = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 10) begin bus.start = 1'b1; bus.r2 = 32'd10; bus.r3 = 32'd2; end
      if (i == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin p++; if (lat == 0) begin lat = i; r = bus.r1; end end
    end
    total++; if (p != 1) begin bad++; $display("FAIL ignore_pulses got=%0d want=1", p); end
    total++; if (lat != 34) begin bad++; $display("FAIL ignore_latency got=%0d want=34", lat); end
    total++; if (r !== 32'd1) begin bad++; $display("FAIL ignore_r1 got=%h want=1", r); end
  endtask

  task automatic test_rst_mid_run();
    logic [N-1:0] r; logic e; int lat, p;
    int pulses = 0;
    @(negedge clk);
    bus.r2 = 32'd1; bus.r3 = 32'd9; bus.start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 15) rst = 1'b1;
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    total++; if (bus.r1 !== 32'd0) begin bad++; $display("FAIL abort_r1 got=%h want=0", bus.r1); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", bus.done); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
    run_op(-32'sd3, 32'd2, r, e, lat, p);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL after_abort_r1 got=%h want=1", r); end
    total++; if (lat != 34) begin bad++; $display("FAIL after_abort_latency got=%0d want=34", lat); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ea, eb;
    logic exp_lt;
    int got = 0, cyc = 0, guard = 0;
    @(negedge clk);
    ea = $urandom; eb = $urandom;
    bus.r2 = ea; bus.r3 = eb; bus.start = 1'b1;
    while (got < 1000 && guard < 1000 * 34 + 200) begin
      @(negedge clk);
      guard++; cyc++;
      if (bus.done === 1'b1) begin
        exp_lt = ($signed(ea) < $signed(eb));
        total++; if (bus.r1 !== {31'b0, exp_lt}) begin
          bad++; $display("FAIL b2b_r1 #%0d r2=%h r3=%h got=%h want=%0d", got, ea, eb, bus.r1, exp_lt);
        end
        total++; if (bus.eq !== (ea == eb)) begin
          bad++; $display("FAIL b2b_eq #%0d got=%b want=%b", got, bus.eq, (ea == eb));
        end
        total++; if (cyc != 34) begin bad++; $display("FAIL b2b_period #%0d got=%0d want=34", got, cyc); end
        cyc = 0; got++;
        ea = $urandom; eb = $urandom;
        if (got % 50 == 0) eb = ea;
        bus.r2 = ea; bus.r3 = eb;
      end else if (bus.busy === 1'b1) begin
        bus.r2 = $urandom; bus.r3 = $urandom;
      end
    end
    bus.start = 1'b0;
    total++; if (got != 1000) begin bad++; $display("FAIL b2b_timeout got=%0d want=1000", got); end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.r2 = '0; bus.r3 = '0;
`ifdef SLT_SERIAL_UNSIGNED_EN
    bus.uns = 1'b0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_equal();
    test_hold();
    test_ignore_start();
    test_rst_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slt_serial.md
SLT_SERIAL -- requirements
Module: slt_serial

Interface
REQ-001: Parameter n, default 32, operand and result width in bits (n >= 2).
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004: start  input  1  request to begin a comparison; sampled only in IDLE.
REQ-005: r2  input  n  first operand (signed two's complement); captured when start is accepted.
REQ-006: r3  input  n  second operand (signed two's complement); captured when start is accepted.
REQ-007: busy  output  1  high in RUN and DONE; low in IDLE.
REQ-008: done  output  1  one-cycle pulse marking r1 valid for the current operation.
REQ-009: r1  output  n  comparison result: 1 if r2 < r3, else 0, zero-extended to n bits.
REQ-010: eq  output  1  high when captured r2 == r3, valid with done.

Function
REQ-011: States SHALL be IDLE, RUN and DONE, held in a registered state variable.
REQ-012: In IDLE with start=1, SHALL capture r2 and r3 into shift registers, clear bit counter to 0, set carry register to 1, set the zero flag to 1, and enter RUN.
REQ-013: In RUN, each cycle SHALL compute one bit of r2 + ~r3 + carry, LSB first, updating the carry, shifting both operands right by one, and clearing the zero flag if the sum bit is 1.
REQ-014: On the RUN cycle with counter = n-1 (the MSB), SHALL record the sum MSB, carry-in and carry-out of that bit, then enter DONE.
REQ-015: Signed less-than SHALL be sum_msb XOR (carry_in_msb XOR carry_out_msb), i.e. the subtraction sign corrected for overflow; eq SHALL be the final zero flag.
REQ-016: In DONE, r1 and eq SHALL be loaded, done SHALL be 1 for exactly that cycle, and the next state SHALL be IDLE.
REQ-017: Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+n+1, i.e. n+2 cycles from the start edge to the done cycle inclusive.
REQ-018: start asserted in RUN or DONE SHALL be ignored; no queuing, operands unchanged.
REQ-019: r1 and eq SHALL hold their last values through IDLE until the next DONE.
REQ-020: start held high continuously SHALL produce back-to-back operations, one per n+2 cycles.
REQ-021: Operand inputs changing during RUN SHALL have no effect on the result.

Reset
REQ-022: rst=1 SHALL force IDLE, r1=0, eq=0, done=0, busy=0, counter=0, and carry=0, taking priority over start.
REQ-023: rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave as a fresh operation.

Configuration
REQ-024: Macro SLT_SERIAL_UNSIGNED_EN defined: an extra input port uns (1 bit, captured with the operands) SHALL exist; when uns=1, less-than SHALL be ~carry_out_msb (unsigned borrow); when uns=0, the behaviour of REQ-015 applies.
REQ-025: Macro undefined: the uns port SHALL NOT exist and the comparison SHALL always be signed per REQ-015.

Verification
REQ-026: n=32, r2=5, r3=7, start pulse -> done exactly 34 cycles after the start edge, r1=1, eq=0.
REQ-027: r2=0x80000000, r3=0x7FFFFFFF (signed overflow case) -> r1=1; swapped operands -> r1=0; with the macro defined and uns=1 -> r1=0 then r1=1.
REQ-028: r2=r3=0xFFFFFFFF -> r1=0, eq=1; r2=0xFFFFFFFF, r3=0 -> r1=1, eq=0.
REQ-029: start re-pulsed at cycle 10 of RUN with different operands -> ignored, result matches the first operands, single done pulse.
REQ-030: rst asserted at cycle 15 of RUN -> no done pulse, r1=0, busy=0 the next cycle; a following start r2=-3, r3=2 -> r1=1.
REQ-031: Random signed pairs, 1000 iterations, start held high -> every r1 equals ($signed(r2) < $signed(r3)), with one done pulse per 34 cycles.
